// File: rtl/bram_read_arbiter.sv
`timescale 1ns/1ps
// Shares one synchronous-read BRAM port between two burst-read requesters and tags returning data.
// Build option: define ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 wins), otherwise round-robin.
module bram_read_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [5:0]        len0,
    input  logic [5:0]        len1,
    output logic              grant0,
    output logic              grant1,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid0,
    output logic              rd_valid1,
    output logic              done0,
    output logic              done1,
    output logic              busy
);
    localparam int DCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [5:0]        cnt_max_q, cnt_max_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [RD_LAT-1:0] tag_en_q;
    logic [RD_LAT-1:0] tag_own_q;
    logic              win_s;

`ifdef ARB_FIXED_PRIORITY_EN
    // Winner selection: requester 0 wins whenever it is asking.
    always_comb begin
        if (req0) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
    end
`else
    logic last_owner_q, last_owner_d;

    // Winner selection: on contention the requester not served last time wins.
    always_comb begin
        if (req0 && req1) begin
            win_s = ~last_owner_q;
        end else if (req0) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
    end

    // Remember who was granted most recently.
    always_comb begin
        if ((state_q == S_IDLE) && (req0 || req1)) begin
            last_owner_d = win_s;
        end else begin
            last_owner_d = last_owner_q;
        end
    end

    // Round-robin history register; resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= 1'b1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    // State and burst context registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            base_q    <= '0;
            cnt_q     <= 6'd0;
            cnt_max_q <= 6'd0;
            dcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            cnt_max_q <= cnt_max_d;
            dcnt_q    <= dcnt_d;
        end
    end

    // Next-state and burst bookkeeping.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        cnt_max_d = cnt_max_q;
        dcnt_d    = dcnt_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d   = S_ISSUE;
                    owner_d   = win_s;
                    base_d    = win_s ? addr1 : addr0;
                    cnt_max_d = win_s ? len1 : len0;
                    cnt_d     = 6'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (cnt_q == cnt_max_q) begin
                    state_d = S_DRAIN;
                    dcnt_d  = DCNT_LOAD;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            // Wait out the read latency so the last word is tagged before done.
            S_DRAIN: begin
                if (dcnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    dcnt_d = dcnt_q - DCNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the current state and owner.
    always_comb begin
        mem_en   = 1'b0;
        mem_addr = '0;
        grant0   = 1'b0;
        grant1   = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = base_q + ADDR_W'(cnt_q);
                grant0   = ~owner_q;
                grant1   = owner_q;
                busy     = 1'b1;
            end
            S_DRAIN: begin
                grant0 = ~owner_q;
                grant1 = owner_q;
                busy   = 1'b1;
            end
            S_DONE: begin
                grant0 = ~owner_q;
                grant1 = owner_q;
                done0  = ~owner_q;
                done1  = owner_q;
                busy   = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Tag pipeline: follows each issued read until its data returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_en_q  <= '0;
            tag_own_q <= '0;
        end else begin
            tag_en_q[0]  <= mem_en;
            tag_own_q[0] <= owner_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_en_q[i]  <= tag_en_q[i-1];
                tag_own_q[i] <= tag_own_q[i-1];
            end
        end
    end

    assign rd_data   = mem_dout;
    assign rd_valid0 = tag_en_q[RD_LAT-1] & ~tag_own_q[RD_LAT-1];
    assign rd_valid1 = tag_en_q[RD_LAT-1] &  tag_own_q[RD_LAT-1];

endmodule

// File: tb/tb_bram_read_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for bram_read_arbiter: each cycle of a burst is compared with a schedule
// computed from the burst rules (first issue at k=0, data at k+RD_LAT, done at L+RD_LAT).
module tb_bram_read_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [5:0]        len0, len1;
    logic              grant0, grant1, mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout, rd_data;
    logic              rd_valid0, rd_valid1, done0, done1, busy;

    logic [DATA_W-1:0] mem  [256];
    logic [DATA_W-1:0] pipe [RD_LAT];
    int n_checks = 0;
    int n_fail   = 0;

    bram_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .len0(len0), .len1(len1),
        .grant0(grant0), .grant1(grant1),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .rd_data(rd_data),
        .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
        .done0(done0), .done1(done1), .busy(busy)
    );

    always #5 clk = ~clk;

    // BRAM model: data for the address presented in cycle c appears in cycle c+RD_LAT.
    always @(posedge clk) begin
        pipe[0] <= mem[mem_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_dout = pipe[RD_LAT-1];

    // Expected outputs k cycles after the first issue of an L-word burst by owner o from address a.
    function automatic logic [31:0] model_vec(input logic o, input logic [7:0] a, input int L, input int k);
        logic g, en, v, dn;
        logic [7:0] ad, da;
        logic [15:0] dat;
        g   = (k >= 0) && (k <= L + RD_LAT);
        en  = (k >= 0) && (k < L);
        v   = (k >= RD_LAT) && (k < L + RD_LAT);
        dn  = (k == L + RD_LAT);
        ad  = en ? (a + 8'(k)) : 8'h00;
        da  = a + 8'(k - RD_LAT);
        dat = v ? mem[da] : 16'h0000;
        return {g & ~o, g & o, en, ad, v & ~o, v & o, dn & ~o, dn & o, g, dat};
    endfunction

    // Observed outputs in the same layout; address/data only meaningful where expected.
    function automatic logic [31:0] obs_vec(input logic [31:0] e);
        logic [7:0] ad;
        logic [15:0] d;
        ad = e[29] ? mem_addr : 8'h00;
        d  = (e[20] | e[19]) ? rd_data : 16'h0000;
        return {grant0, grant1, mem_en, ad, rd_valid0, rd_valid1, done0, done1, busy, d};
    endfunction

    task automatic drive_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp, got;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 3) reset = 1'b0;
            exp = model_vec(1'b0, 8'h00, 1, -1);
            got = obs_vec(exp);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset i=%0d got=%h exp=%h", i, got, exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [31:0] exp, got;
        addr0 = 8'h10; len0 = 6'd3; req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= 4 + RD_LAT + 1; k++) begin
            exp = model_vec(1'b0, 8'h10, 4, k);
            got = obs_vec(exp);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL single k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == 4 + RD_LAT) req0 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp, got;
        addr1 = 8'hFE; len1 = 6'd3; req1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= 4 + RD_LAT + 1; k++) begin
            exp = model_vec(1'b1, 8'hFE, 4, k);
            got = obs_vec(exp);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL wrap k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == 4 + RD_LAT) req1 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp, got;
        logic m_last, o;
        logic [7:0] a;
        int L;
        drive_reset();
        m_last = 1'b1;
        addr0 = 8'($urandom); len0 = 6'($urandom_range(0, 7));
        addr1 = 8'($urandom); len1 = 6'($urandom_range(0, 7));
        req0 = 1'b1; req1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int b = 0; b < 4; b++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            o = 1'b0;
`else
            o = ~m_last;
`endif
            m_last = o;
            a = o ? addr1 : addr0;
            L = (o ? int'(len1) : int'(len0)) + 1;
            for (int k = 0; k <= L + RD_LAT + 1; k++) begin
                exp = model_vec(o, a, L, k);
                got = obs_vec(exp);
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL contention b=%0d k=%0d got=%h exp=%h", b, k, got, exp);
                end
                if (b == 3 && k == L + RD_LAT) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_max();
        logic [31:0] exp, got;
        logic [7:0] a;
        a = 8'($urandom);
        addr0 = a; len0 = 6'd63; req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= 64 + RD_LAT + 1; k++) begin
            exp = model_vec(1'b0, a, 64, k);
            got = obs_vec(exp);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL max_burst k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == 64 + RD_LAT) req0 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp, got;
        logic [7:0] a;
        int L;
        a = 8'($urandom);
        addr0 = a; len0 = 6'd7; req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            exp = model_vec(1'b0, a, 8, k);
            got = obs_vec(exp);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_pre k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == 2) begin
                reset = 1'b1;
                req0  = 1'b0;
            end
            @(negedge clk);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp = model_vec(1'b0, 8'h00, 1, -1);
            got = obs_vec(exp);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_quiet i=%0d got=%h exp=%h", i, got, exp);
            end
            @(negedge clk);
        end
        a = 8'($urandom);
        L = $urandom_range(1, 16);
        addr1 = a; len1 = 6'(L - 1); req1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= L + RD_LAT + 1; k++) begin
            exp = model_vec(1'b1, a, L, k);
            got = obs_vec(exp);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_fresh k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == L + RD_LAT) req1 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_dropped();
        logic [31:0] exp, got;
        logic [7:0] a;
        a = 8'($urandom);
        addr0 = a; len0 = 6'd7; req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= 8 + RD_LAT + 1; k++) begin
            exp = model_vec(1'b0, a, 8, k);
            got = obs_vec(exp);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL dropped k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == 1) req0 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp, got;
        logic [7:0] a;
        logic o;
        int L, gap;
        for (int b = 0; b < 8; b++) begin
            o   = 1'($urandom_range(0, 1));
            a   = 8'($urandom);
            L   = $urandom_range(1, 64);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                exp = model_vec(o, a, L, -1);
                got = obs_vec(exp);
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random_idle b=%0d got=%h exp=%h", b, got, exp);
                end
                @(negedge clk);
            end
            addr0 = o ? 8'($urandom) : a;
            addr1 = o ? a : 8'($urandom);
            len0  = o ? 6'($urandom) : 6'(L - 1);
            len1  = o ? 6'(L - 1) : 6'($urandom);
            req0  = ~o;
            req1  = o;
            @(posedge clk);
            @(negedge clk);
            for (int k = 0; k <= L + RD_LAT + 1; k++) begin
                exp = model_vec(o, a, L, k);
                got = obs_vec(exp);
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random b=%0d k=%0d got=%h exp=%h", b, k, got, exp);
                end
                addr0 = 8'($urandom);
                addr1 = 8'($urandom);
                if (k == L + RD_LAT) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00;
        len0 = 6'd0; len1 = 6'd0;
        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_max();
        test_reset_mid();
        test_dropped();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_read_arbiter.md
# bram_read_arbiter

Shares one synchronous-read BRAM port between two burst-read requesters, for example the matrix-load sequencer and the debug/readback path. Each requester asks for a contiguous burst of 1–64 words. The arbiter grants one requester at a time, either round-robin or fixed-priority, and issues the addresses. It tracks the BRAM read latency so that returning data is tagged to its owner, and it signals burst completion so the requester can move on.

## Interface
Parameters:
- ADDR_W, 8, BRAM address width.
- DATA_W, 16, BRAM data width.
- RD_LAT, 2, BRAM read latency in cycles (≥1).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  burst request; held high until the matching done pulse.
- addr0 / addr1  in  ADDR_W  burst start address; sampled when the grant is given.
- len0 / len1  in  6  burst length minus 1 (0 → 1 word, 63 → 64 words); sampled with addr.
- grant0 / grant1  out  1  owner indicator; one-hot or zero.
- mem_en  out  1  BRAM read enable.
- mem_addr  out  ADDR_W  BRAM read address.
- mem_dout  in  DATA_W  BRAM read data; valid RD_LAT cycles after the cycle in which mem_en=1.
- rd_data  out  DATA_W  combinational pass-through of mem_dout.
- rd_valid0 / rd_valid1  out  1  rd_data belongs to requester 0 / 1 this cycle.
- done0 / done1  out  1  one-cycle pulse when the burst is complete.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - If any req is high, select the owner, latch addr/len into base/cnt_max, clear cnt, set grant, and go to ISSUE.
- ISSUE:
  - mem_en=1 and mem_addr=base+cnt (mod 2^ADDR_W; wrap-around is legal).
  - cnt increments each cycle.
  - When cnt==cnt_max, go to DRAIN. ISSUE therefore lasts len+1 cycles.
- DRAIN:
  - mem_en=0; a down-counter runs for RD_LAT cycles, then go to DONE.
- DONE:
  - The owner's done pulse is high for one cycle, then go to IDLE.
  - grant is held through DONE and clears on entry to IDLE.
- Tagging:
  - An RD_LAT-deep shift register carries {mem_en, owner}.
  - rd_validN = tap_en & (tap_owner==N).
- Arbitration (default round-robin):
  - Register last_owner is updated on each grant.
  - When both requests are high, the non-last_owner wins.
  - Reset value of last_owner is 1, so req0 wins the first contention.
- A req deasserted mid-burst is ignored; the burst always completes.
- A req still high in IDLE after done is treated as a new burst.
- Owner values other than the granted one never affect mem_addr.

## Timing
- Reset values:
  - grant0/1=0, mem_en=0, mem_addr=0, rd_valid0/1=0, done0/1=0, busy=0.
  - State is IDLE and the tag pipeline is cleared.
- Reset mid-burst aborts immediately. No rd_valid or done is produced for words issued before reset.
- Request → first mem_en: req high in cycle t (IDLE) → grant and mem_en high in cycle t+1.
- Burst of L words with first issue in cycle T:
  - Issues occur in T..T+L−1.
  - rd_valid occurs in T+RD_LAT..T+L−1+RD_LAT.
  - done occurs in T+L+RD_LAT.
  - IDLE is reached in T+L+RD_LAT+1.
- Back-to-back bursts: the earliest next grant is the cycle after IDLE is re-entered (a one-cycle arbitration gap).
- Simultaneous req0 and req1 in IDLE: exactly one grant; the loser waits without losing its request.

## Configuration
- ARB_FIXED_PRIORITY_EN:
  - Defined: requester 0 always wins contention, and last_owner is unused.
  - Undefined: round-robin as described under Operation.
- Burst timing is identical in both builds.

## Test plan
- Single burst: reset, req0 with addr0=0x10 and len0=3, RD_LAT=2.
  - Required: mem_addr 0x10..0x13 on 4 consecutive cycles.
  - Required: rd_valid0 on 4 cycles starting 2 cycles after the first issue.
  - Required: done0 exactly 1 cycle after the last rd_valid0.
  - Required: rd_valid1 and done1 never asserted.
- Wrap-around: req1 with addr1=0xFE and len1=3.
  - Required: mem_addr 0xFE, 0xFF, 0x00, 0x01, with data owned by requester 1.
- Contention: req0 and req1 both asserted in the same cycle after reset.
  - Required: grant0 first, then grant1 after done0.
  - Required: repeating both requests alternates 0, 1, 0, 1 (round-robin build).
  - Required: requester 0 always wins under ARB_FIXED_PRIORITY_EN.
- Max burst: len0=63.
  - Required: 64 issues, 64 rd_valid0, one done0, busy high for 64+2+1 cycles.
- Reset mid-burst: assert reset on the 3rd issue cycle.
  - Required: next cycle all outputs 0.
  - Required: no rd_valid or done afterwards.
  - Required: a fresh req1 is served normally.
- Request dropped: req0 deasserted after the 2nd issue of an 8-word burst.
  - Required: all 8 words still issued and tagged, followed by done0.
